// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: constants and helpers shared by the ALU sequencer, its command
// FIFO and the serializer-side checks.
//   - opcode constants (AND/OR/ADD/SUB)
//   - CTL error codes produced by the deserializer
//   - error-flag (ef) masks and bit positions
//   - sequencer FSM state enum (explicit legacy encodings)
//   - crc3_d37: CRC3 (x^3+x+1, init 0) over {c[31:0],1'b0,flags[3:0]}, MSB first
//   - err_ctl: builds an error response byte {1,ef,ef,parity}
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam logic [7:0] CTL_ERR_DATA = 8'b1100_1001;
  localparam logic [7:0] CTL_ERR_CRC  = 8'b1010_0101;

  localparam int unsigned EF_DATA_BIT = 2;
  localparam int unsigned EF_CRC_BIT  = 1;
  localparam int unsigned EF_OP_BIT   = 0;

  localparam logic [2:0] EF_DATA = 3'b100;
  localparam logic [2:0] EF_CRC  = 3'b010;
  localparam logic [2:0] EF_OP   = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLASSIFY = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  function automatic logic [2:0] crc3_d37(input logic [36:0] d);
    logic [2:0] crc;
    logic       fb;
    crc = '0;
    for (int unsigned i = 0; i < 37; i++) begin
      fb  = d[36-i] ^ crc[2];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

  // Parity bit makes {1,ef,ef,par} even over bits [7:1] plus itself.
  function automatic logic [7:0] err_ctl(input logic [2:0] ef);
    return {1'b1, ef, ef, ^{1'b1, ef, ef}};
  endfunction

endpackage

// File: rtl/mtm_alu_cmd_fifo.sv
// mtm_alu_cmd_fifo: DEPTH x WIDTH synchronous command FIFO.
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   push, din  write request / data (ignored when full unless popping too)
//   pop        read request (ignored when empty)
//   dout       head entry (combinational read of the storage array)
//   full/empty registered occupancy flags
module mtm_alu_cmd_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 72
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/mtm_alu_sequencer.sv
// mtm_alu_sequencer: command scheduler between deserializer and ALU core.
// Queues {A,B,CTL} commands, answers error codes directly, issues valid ops
// to the multi-cycle core and holds each response until accepted.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_valid/in_ready        command handshake; in_a, in_b, in_ctl payload
//   alu_start                one-cycle issue pulse; alu_op/alu_a/alu_b operands
//   alu_done, alu_c, alu_flags  core result (sampled only while waiting)
//   out_valid/out_ready      response handshake; out_is_err, out_c, out_ctl
//   busy                     queue non-empty or FSM active
//   timeout                  sticky: an op exceeded ALU_TIMEOUT cycles
module mtm_alu_sequencer
  import mtm_alu_pkg::*;
#(
  parameter int unsigned CMD_DEPTH   = 2,
  parameter int unsigned ALU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [7:0]  in_ctl,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_done,
  input  logic [31:0] alu_c,
  input  logic [3:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_err,
  output logic [31:0] out_c,
  output logic [7:0]  out_ctl,
  output logic        busy,
  output logic        timeout
);

  localparam int unsigned TW = $clog2(ALU_TIMEOUT);

  state_t        state;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [71:0]   head;
  logic [7:0]    cmd_ctl;
  logic [2:0]    cls_ef;
  logic [TW-1:0] timer;

  assign in_ready  = ~fifo_full;
  assign push      = in_valid & in_ready;
  assign pop       = (state == ST_IDLE) & ~fifo_empty;
  assign alu_start = (state == ST_ISSUE);
  assign out_valid = (state == ST_RESP);
  assign busy      = ~fifo_empty | (state != ST_IDLE);

  mtm_alu_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (72)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({in_a, in_b, in_ctl}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    cls_ef = '0;
    if (cmd_ctl == CTL_ERR_DATA)
      cls_ef = EF_DATA;
    else if (cmd_ctl == CTL_ERR_CRC)
      cls_ef = EF_CRC;
    else if (cmd_ctl[7] || !(cmd_ctl[6:4] inside {OP_AND, OP_OR, OP_ADD, OP_SUB}))
      cls_ef = EF_OP;
  end

  // Operands go straight from the queue head into the core-facing registers
  // at pop time; they then stay untouched until the next pop, which covers
  // the whole start..done window without a second operand copy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      cmd_ctl    <= '0;
      timer      <= '0;
      timeout    <= 1'b0;
      out_is_err <= 1'b0;
      out_c      <= '0;
      out_ctl    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {alu_a, alu_b, cmd_ctl} <= head;
            alu_op                  <= head[6:4];
            state                   <= ST_CLASSIFY;
          end
        end
        ST_CLASSIFY: begin
          if (cls_ef != '0) begin
            out_is_err <= 1'b1;
            out_c      <= '0;
            out_ctl    <= err_ctl(cls_ef);
            state      <= ST_RESP;
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_done) begin
            out_is_err <= 1'b0;
            out_c      <= alu_c;
            out_ctl    <= {1'b0, alu_flags, crc3_d37({alu_c, 1'b0, alu_flags})};
            state      <= ST_RESP;
          end else if (timer == TW'(ALU_TIMEOUT - 1)) begin
            timeout    <= 1'b1;
            out_is_err <= 1'b1;
            out_c      <= '0;
            out_ctl    <= err_ctl(EF_OP);
            state      <= ST_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_sequencer.sv
`timescale 1ns/1ps
module tb_mtm_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [7:0]  in_ctl = '0;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_done = 1'b0;
  logic [31:0] alu_c = '0;
  logic [3:0]  alu_flags = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_is_err;
  logic [31:0] out_c;
  logic [7:0]  out_ctl;
  logic        busy;
  logic        timeout;

  always #5 clk = ~clk;

  mtm_alu_sequencer #(
    .CMD_DEPTH   (2),
    .ALU_TIMEOUT (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ctl     (in_ctl),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_c      (alu_c),
    .alu_flags  (alu_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_is_err (out_is_err),
    .out_c      (out_c),
    .out_ctl    (out_ctl),
    .busy       (busy),
    .timeout    (timeout)
  );

  typedef struct packed {
    logic        is_err;
    logic [31:0] c;
    logic [7:0]  ctl;
  } resp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [3:0]  flags;
  } core_t;

  resp_t exp_q[$];
  core_t core_q[$];
  resp_t mon_e;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;
  int n_issue_exp = 0;
  int last_start_cyc = 0;
  int lat = 1;
  bit stall = 1'b0;

  // Remainder of M(x)*x^3 divided by x^3+x+1 (long division).
  function automatic logic [2:0] ref_crc(input logic [36:0] m);
    logic [39:0] v;
    v = {m, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (v[i]) v[i-:4] = v[i-:4] ^ 4'b1011;
    return v[2:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor / scoreboard.
  logic        hold_prev = 1'b0;
  logic [31:0] prev_c = '0;
  logic [7:0]  prev_ctl = '0;
  always @(negedge clk) begin
    if (alu_start === 1'b1) begin
      n_start++;
      last_start_cyc = cyc;
    end
    if (out_valid === 1'b1) begin
      if (hold_prev) begin
        check("hold_out_c", out_c, prev_c);
        check("hold_out_ctl", out_ctl, prev_ctl);
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp: got c=%0h ctl=%0h, required no response", out_c, out_ctl);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_is_err", out_is_err, mon_e.is_err);
          check("out_c", out_c, mon_e.c);
          check("out_ctl", out_ctl, mon_e.ctl);
        end
      end
    end
    hold_prev = (out_valid === 1'b1) && !out_ready;
    prev_c    = out_c;
    prev_ctl  = out_ctl;
  end

  // ALU core stub: checks issued operands, answers after 'lat' cycles.
  initial begin
    core_t cur;
    bit    pend;
    int    cnt;
    pend = 1'b0;
    cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      alu_done  = 1'b0;
      alu_c     = 32'hBAD0_BAD0;
      alu_flags = 4'hF;
      if (pend) begin
        if (cnt == 0) begin
          alu_done  = 1'b1;
          alu_c     = cur.c;
          alu_flags = cur.flags;
          pend      = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (alu_start === 1'b1 && !stall) begin
        if (core_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stray_start: got alu_start=1 op=%0h, required no issue", alu_op);
        end else begin
          cur = core_q.pop_front();
          check("alu_op", alu_op, cur.op);
          check("alu_a", alu_a, cur.a);
          check("alu_b", alu_b, cur.b);
          pend = 1'b1;
          cnt  = lat - 1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_wait: got in_ready=0 required 1");
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_ctl   = ctl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl,
                           input logic [31:0] c, input logic [3:0] flags, input logic [7:0] exp_ctl);
    core_q.push_back('{op: ctl[6:4], a: a, b: b, c: c, flags: flags});
    exp_q.push_back('{is_err: 1'b0, c: c, ctl: exp_ctl});
    n_issue_exp++;
    send(a, b, ctl);
  endtask

  task automatic expect_err(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl,
                            input logic [7:0] exp_ctl);
    exp_q.push_back('{is_err: 1'b1, c: 32'h0, ctl: exp_ctl});
    send(a, b, ctl);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || out_valid || exp_q.size() != 0) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_wait: got busy=%0b pending=%0d, required idle", busy, exp_q.size());
    end
  endtask

  initial begin
    int s0;
    int t;
    logic [31:0] c_and;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_out_c", out_c, 0);
    check("rst_out_ctl", out_ctl, 0);
    check("rst_out_is_err", out_is_err, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: ADD 1+2 -> c=3, flags 0, CRC3 = 3'b110
    lat = 2;
    expect_op(32'd1, 32'd2, 8'h40, 32'd3, 4'b0000, 8'h06);
    wait_idle();
    check("t1_start_count", n_start, 1);

    // 2/3: error codes and illegal opcodes
    expect_err(32'h1111_1111, 32'h2222_2222, 8'hC9, 8'hC9);
    expect_err(32'h0, 32'h0, 8'hA5, 8'hA5);
    expect_err(32'h0, 32'h0, 8'h70, 8'h93);
    expect_err(32'h5, 32'h6, 8'h25, 8'h93);
    wait_idle();
    check("t3_no_issue", n_start, 1);

    // More ops, minimal core latency
    lat = 1;
    expect_op(32'd7, 32'd7, 8'h5A, 32'h0, 4'b0010, 8'h16);
    expect_op(32'h8000_0000, 32'h0, 8'h13, 32'h8000_0000, 4'b0001, 8'h0D);
    c_and = 32'h1234_5678;
    expect_op(32'h1234_5678, 32'hFFFF_FFFF, 8'h07, c_and, 4'b0000,
              {1'b0, 4'b0000, ref_crc({c_and, 1'b0, 4'b0000})});
    wait_idle();

    // 4: back-pressure fills the queue
    lat = 3;
    out_ready = 1'b0;
    expect_op(32'd10, 32'd20, 8'h4C, 32'd30, 4'b0000,
              {1'b0, 4'b0000, ref_crc({32'd30, 1'b0, 4'b0000})});
    expect_err(32'h0, 32'h0, 8'hC9, 8'hC9);
    expect_op(32'd5, 32'd9, 8'h53, 32'hFFFF_FFFC, 4'b1001,
              {1'b0, 4'b1001, ref_crc({32'hFFFF_FFFC, 1'b0, 4'b1001})});
    check("t4_full_in_ready", in_ready, 0);
    repeat (20) @(posedge clk);
    #1;
    check("t4_held_in_ready", in_ready, 0);
    check("t4_held_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_idle();
    check("t4_in_ready_after", in_ready, 1);

    // 5: core never answers
    stall = 1'b1;
    exp_q.push_back('{is_err: 1'b1, c: 32'h0, ctl: 8'h93});
    n_issue_exp++;
    send(32'd1, 32'd1, 8'h40);
    t = 0;
    while (timeout !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("t5_timeout", timeout, 1);
    check("t5_timeout_delay", cyc - last_start_cyc, 65);
    wait_idle();
    stall = 1'b0;
    check("t5_timeout_sticky", timeout, 1);

    // 6: reset during WAIT with one command queued
    lat = 10;
    s0 = n_start;
    expect_op(32'd3, 32'd4, 8'h40, 32'd7, 4'b0000, 8'h00);
    expect_op(32'd8, 32'd9, 8'h40, 32'd17, 4'b0000, 8'h00);
    t = 0;
    while (n_start == s0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("t6_started", n_start, s0 + 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    core_q.delete();
    n_issue_exp--;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_timeout_cleared", timeout, 0);
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_resp", out_valid, 0);

    // Recovery after reset
    lat = 1;
    expect_op(32'd2, 32'd2, 8'h4F, 32'd4, 4'b0000,
              {1'b0, 4'b0000, ref_crc({32'd4, 1'b0, 4'b0000})});
    wait_idle();

    check("all_resp_seen", exp_q.size(), 0);
    check("issue_count", n_start, n_issue_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
